// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ahb_pkg
// Description : Shared AHB-Lite encodings and slave FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slv_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : sram_1r1w
// Description : DEPTH x 32 memory, one registered read port, one write port.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ahb_slave_sram.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_sram
// Description : AHB-Lite SRAM slave with wait states, ERROR response and
//               read-after-write forwarding for pipelined transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_sram
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        i_clk_ahb,
    input  logic        i_rst_ahb,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int          c_IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] c_SPAN      = 32'(DEPTH * 4);
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_t         r_state;
    slv_state_t         w_state_nxt;
    logic [3:0]         r_wait_cnt;
    logic [3:0]         w_wait_cnt_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_is_write;
    logic               r_fwd_sel;
    logic [31:0]        r_fwd_data;

    htrans_t            w_trans;
    logic [31:0]        w_offset;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_ready;
    logic               w_accept;
    logic               w_err;
    logic               w_we;
    logic               w_rd_en;
    logic               w_fwd;
    logic [31:0]        w_sram_rdata;

    assign w_trans  = htrans_t'(HTRANS);
    assign w_offset = HADDR - BASE_ADDR;
    assign w_idx    = w_offset[c_IDX_W+1:2];
    assign w_ready  = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign w_accept = HSEL && HREADY && w_ready && ((w_trans == NONSEQ) || (w_trans == SEQ));
    assign w_err    = (w_offset >= c_SPAN) || (HADDR[1:0] != 2'b00) || (HSIZE != HSIZE_WORD);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
                end
            end
            S_ERR1: w_state_nxt = S_ERR2;
            default: begin
                if (w_accept && w_err) begin
                    w_state_nxt = S_ERR1;
                end else if (w_accept && (WAIT_STATES > 0)) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = c_WAIT_INIT;
                end else if (w_accept) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // The array read fires on the edge entering DATA; the index comes from the
    // bus when there are no wait states, otherwise from the latched address.
    assign w_we     = (r_state == S_DATA) && r_is_write && !i_rst_ahb;
    assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;
    assign w_rd_en  = !i_rst_ahb && (w_state_nxt == S_DATA) &&
                      ((r_state == S_WAIT) ? !r_is_write : !HWRITE);
    assign w_fwd    = (r_state == S_DATA) && r_is_write && (w_rd_idx == r_idx);

    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 4'd0;
            r_idx      <= '0;
            r_is_write <= 1'b0;
            r_fwd_sel  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_accept) begin
                r_idx      <= w_idx;
                r_is_write <= HWRITE && !w_err;
            end
            if (w_rd_en) begin
                r_fwd_sel <= w_fwd;
                if (w_fwd) begin
                    r_fwd_data <= HWDATA;
                end
            end
        end
    end

    sram_1r1w #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_IDX_W)
    ) u_sram (
        .i_clk   (i_clk_ahb),
        .i_rst   (i_rst_ahb),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_idx),
        .o_rdata (w_sram_rdata),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (HWDATA)
    );

    assign HREADYOUT = w_ready;
    assign HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = r_fwd_sel ? r_fwd_data : w_sram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_sram.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_sram
// Description : Randomized bench for ahb_slave_sram at 0, 2 and 3 wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_sram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hsel      [3];
    logic [31:0] haddr     [3];
    logic [1:0]  htrans    [3];
    logic        hwrite    [3];
    logic [2:0]  hsize     [3];
    logic [31:0] hwdata    [3];
    logic        hready    [3];
    logic        hreadyout [3];
    logic [31:0] hrdata    [3];
    logic        hresp     [3];

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];
    assign hready[2] = hreadyout[2];

    ahb_slave_sram #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(0)) u_dut_ws0 (
        .i_clk_ahb(clk), .i_rst_ahb(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
        .HREADYOUT(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]));

    ahb_slave_sram #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(2)) u_dut_ws2 (
        .i_clk_ahb(clk), .i_rst_ahb(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
        .HREADYOUT(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]));

    ahb_slave_sram #(.BASE_ADDR(32'h0), .DEPTH(16), .WAIT_STATES(3)) u_dut_ws3 (
        .i_clk_ahb(clk), .i_rst_ahb(rst), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
        .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HWDATA(hwdata[2]), .HREADY(hready[2]),
        .HREADYOUT(hreadyout[2]), .HRDATA(hrdata[2]), .HRESP(hresp[2]));

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       q [$];
    logic [31:0] mem_m   [3][16];
    logic [31:0] last_rd [3];
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit is_noop(input xfer_t x);
        return !(x.sel && (x.trans == 2'b10 || x.trans == 2'b11));
    endfunction

    function automatic bit is_err(input xfer_t x);
        if (is_noop(x)) return 1'b0;
        return (x.addr >= 32'd64) || (x.addr % 4 != 0) || (x.size != 3'b010);
    endfunction

    task automatic push(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        q.push_back(x);
    endtask

    task automatic drive_addr(input int k, input bit v, input xfer_t x);
        hsel[k]   = v ? x.sel   : 1'b0;
        htrans[k] = v ? x.trans : 2'b00;
        hwrite[k] = v ? x.wr    : 1'b0;
        hsize[k]  = v ? x.size  : 3'b010;
        haddr[k]  = v ? x.addr  : 32'h0;
    endtask

    task automatic retire(input int k, input xfer_t dp, input int waits,
                          input logic rs, input logic [31:0] rd);
        bit nop;
        bit e;
        int idx;
        int exp_w;
        nop   = is_noop(dp);
        e     = is_err(dp);
        idx   = int'((dp.addr / 4) % 16);
        exp_w = nop ? 0 : (e ? 1 : ws_of(k));
        chk($sformatf("ws%0d_waits_%h", ws_of(k), dp.addr), 32'(waits), 32'(exp_w));
        chk($sformatf("ws%0d_resp_%h", ws_of(k), dp.addr), 32'(rs), 32'(e));
        if (!nop && !e && !dp.wr) begin
            chk($sformatf("ws%0d_rdata_%h", ws_of(k), dp.addr), rd, mem_m[k][idx]);
            last_rd[k] = mem_m[k][idx];
        end else begin
            chk($sformatf("ws%0d_rd_hold", ws_of(k)), rd, last_rd[k]);
        end
        if (!nop && !e && dp.wr) mem_m[k][idx] = dp.wdata;
    endtask

    // Pipelined master: address of the next transfer overlaps the data phase
    // of the current one; responses are sampled on the falling edge.
    task automatic run_q(input int k);
        xfer_t       ap;
        xfer_t       dp;
        bit          ap_v;
        bit          dp_v;
        bit          r;
        logic        rs;
        logic [31:0] rd;
        int          waits;
        int          cycles;
        ap_v = 1'b0; dp_v = 1'b0; waits = 0; cycles = 0;
        ap = '{default: '0}; dp = '{default: '0};
        @(posedge clk); #1;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
        drive_addr(k, ap_v, ap);
        while (ap_v || dp_v) begin
            @(negedge clk);
            r = hreadyout[k]; rs = hresp[k]; rd = hrdata[k];
            cycles++;
            if (dp_v) begin
                if (r) retire(k, dp, waits, rs, rd);
                else begin
                    waits++;
                    chk($sformatf("ws%0d_wait_resp", ws_of(k)), 32'(rs), 32'(is_err(dp)));
                end
            end else begin
                chk($sformatf("ws%0d_idle_ready", ws_of(k)), 32'(r), 32'd1);
            end
            if (waits > 20 || cycles > 2000) begin
                chk($sformatf("ws%0d_timeout", ws_of(k)), 32'(cycles + waits), 32'd0);
                q.delete();
                drive_addr(k, 1'b0, ap);
                return;
            end
            @(posedge clk); #1;
            if (r) begin
                dp    = ap;
                dp_v  = ap_v;
                waits = 0;
                hwdata[k] = (dp_v && dp.wr) ? dp.wdata : $urandom;
                ap_v = 1'b0;
                if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
                drive_addr(k, ap_v, ap);
            end
        end
    endtask

    task automatic rand_q(input int n);
        for (int i = 0; i < n; i++) begin
            int          p;
            logic [1:0]  tr;
            logic [2:0]  sz;
            logic [31:0] a;
            p  = $urandom_range(0, 99);
            tr = (p >= 85 && p < 92) ? 2'($urandom_range(0, 1)) : ($urandom_range(0, 1) ? 2'b10 : 2'b11);
            sz = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 3)) * 4;
            else                           a = 32'($urandom_range(0, 15)) * 4;
            if ($urandom_range(0, 14) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 14) == 0) a = $urandom;
            push(p < 92, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int k = 0; k < 3; k++) begin
            drive_addr(k, 1'b0, '{default: '0});
            hwdata[k]  = 32'h0;
            last_rd[k] = 32'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ws%0d_reset_hreadyout", ws_of(k)), 32'(hreadyout[k]), 32'd1);
            chk($sformatf("ws%0d_reset_hresp", ws_of(k)), 32'(hresp[k]), 32'd0);
            chk($sformatf("ws%0d_reset_hrdata", ws_of(k)), hrdata[k], 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) push(1'b1, 2'b10, 1'b1, 3'b010, 32'(i * 4), $urandom);
            run_q(k);
        end

        // Write then immediately read the same word (forwarding at 0 waits).
        push(1'b1, 2'b10, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        push(1'b1, 2'b11, 1'b0, 3'b010, 32'h20, 32'h0);
        run_q(0);
        push(1'b1, 2'b10, 1'b1, 3'b010, 32'h24, 32'hCAFEBABE);
        push(1'b1, 2'b10, 1'b0, 3'b010, 32'h24, 32'h0);
        run_q(1);
        push(1'b1, 2'b10, 1'b0, 3'b010, 32'h40, 32'h0);
        run_q(0);
        push(1'b1, 2'b10, 1'b1, 3'b000, 32'h28, 32'hFEEDFACE);
        push(1'b1, 2'b10, 1'b1, 3'b010, 32'h2A, 32'hFEEDFACE);
        push(1'b1, 2'b10, 1'b0, 3'b010, 32'h28, 32'h0);
        run_q(0);
        push(1'b1, 2'b01, 1'b0, 3'b010, 32'h2C, 32'h0);
        push(1'b0, 2'b10, 1'b1, 3'b010, 32'h2C, 32'hBABEFACE);
        push(1'b1, 2'b10, 1'b0, 3'b010, 32'h2C, 32'h0);
        run_q(0);

        // Reset while a write sits in its wait states.
        @(posedge clk); #1;
        hsel[2] = 1'b1; htrans[2] = 2'b10; hwrite[2] = 1'b1; hsize[2] = 3'b010; haddr[2] = 32'h30;
        @(posedge clk); #1;
        hwdata[2] = 32'hFEE8788A;
        drive_addr(2, 1'b0, '{default: '0});
        @(negedge clk);
        chk("ws3_wait_before_rst", 32'(hreadyout[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ws3_after_rst_hreadyout", 32'(hreadyout[2]), 32'd1);
        chk("ws3_after_rst_hresp", 32'(hresp[2]), 32'd0);
        chk("ws3_after_rst_hrdata", hrdata[2], 32'd0);
        for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
        push(1'b1, 2'b10, 1'b0, 3'b010, 32'h30, 32'h0);
        run_q(2);

        for (int k = 0; k < 3; k++) begin
            rand_q(80);
            run_q(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
